// File: rtl/logic_unit_pipe.sv
// Two-stage valid/ready logic unit: eight bitwise ops on a/b, compare flags,
// sticky flag accumulation and a saturating delivered-beat counter.
module logic_unit_pipe #(
  parameter int WIDTH  = 16,
  parameter bit SIGNED = 1'b0,
  parameter int CNT_W  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [2:0]         opcode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] outlu,
  output logic               za,
  output logic               zb,
  output logic               eq,
  output logic               gt,
  output logic               lt,
  input  logic               flag_clr,
  output logic [4:0]         sticky_flags,
  output logic [CNT_W-1:0]   op_count
);

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
  } s1_t;

  s1_t                s1;
  logic [2:1]         vld_pipe;
  logic               adv1, adv2, dlv;
  logic [WIDTH-1:0]   lo;
  logic [2*WIDTH-1:0] res;
  logic               gt_c, lt_c;
  logic [4:0]         flg_c, flg_q;

  assign adv2      = !vld_pipe[2] || out_ready;
  assign adv1      = !vld_pipe[1] || adv2;
  assign in_ready  = adv1;
  assign out_valid = vld_pipe[2];
  assign dlv       = vld_pipe[2] && out_ready;

  always_comb begin
    lo = '0;
    case (s1.op)
      3'd0:    lo = s1.a & s1.b;
      3'd1:    lo = s1.a | s1.b;
      3'd2:    lo = s1.a ^ s1.b;
      3'd3:    lo = ~(s1.a & s1.b);
      3'd4:    lo = ~(s1.a | s1.b);
      3'd5:    lo = ~(s1.a ^ s1.b);
      default: lo = ~s1.a;
    endcase
    res = (s1.op == 3'd7) ? {s1.a, s1.b} : {{WIDTH{1'b0}}, lo};
  end

  generate
    if (SIGNED) begin : g_cmp_s
      assign gt_c = $signed(s1.a) > $signed(s1.b);
      assign lt_c = $signed(s1.a) < $signed(s1.b);
    end else begin : g_cmp_u
      assign gt_c = s1.a > s1.b;
      assign lt_c = s1.a < s1.b;
    end
  endgenerate

  assign flg_c = {s1.a == '0, s1.b == '0, s1.a == s1.b, gt_c, lt_c};
  assign {za, zb, eq, gt, lt} = flg_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe     <= '0;
      outlu        <= '0;
      flg_q        <= '0;
      sticky_flags <= '0;
      op_count     <= '0;
    end else begin
      if (adv1) vld_pipe[1] <= in_valid;
      if (adv1 && in_valid) s1 <= '{a: a, b: b, op: opcode};
      if (adv2) vld_pipe[2] <= vld_pipe[1];
      if (adv2 && vld_pipe[1]) begin
        outlu <= res;
        flg_q <= flg_c;
      end
      // a clear coinciding with a delivery restarts accumulation from that beat
      if (flag_clr) begin
        sticky_flags <= dlv ? flg_q : 5'd0;
        op_count     <= dlv ? CNT_W'(1) : '0;
      end else if (dlv) begin
        sticky_flags <= sticky_flags | flg_q;
        if (!(&op_count)) op_count <= op_count + 1'b1;
      end
    end
  end

  // s1 payload carries no reset; it is qualified by vld_pipe[1]
endmodule

// File: tb/tb_logic_unit_pipe.sv
// Scoreboard bench: an unsigned 16-bit-counter unit and a signed 4-bit-counter
// unit share stimulus; a negedge monitor pops expected beats and tracks sticky/count.
module tb_logic_unit_pipe;
  logic        clk = 1'b0;
  logic        rst, in_valid, out_ready, flag_clr;
  logic [15:0] a, b;
  logic [2:0]  opcode;

  logic        in_ready, out_valid, za, zb, eq, gt, lt;
  logic [31:0] outlu;
  logic [4:0]  sticky;
  logic [15:0] cnt;
  logic        in_ready2, out_valid2, za2, zb2, eq2, gt2, lt2;
  logic [31:0] outlu2;
  logic [4:0]  sticky2;
  logic [3:0]  cnt2;

  logic_unit_pipe #(.WIDTH(16), .SIGNED(1'b0), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .opcode(opcode), .out_valid(out_valid), .out_ready(out_ready), .outlu(outlu),
    .za(za), .zb(zb), .eq(eq), .gt(gt), .lt(lt), .flag_clr(flag_clr),
    .sticky_flags(sticky), .op_count(cnt));

  logic_unit_pipe #(.WIDTH(16), .SIGNED(1'b1), .CNT_W(4)) dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .a(a), .b(b),
    .opcode(opcode), .out_valid(out_valid2), .out_ready(out_ready), .outlu(outlu2),
    .za(za2), .zb(zb2), .eq(eq2), .gt(gt2), .lt(lt2), .flag_clr(flag_clr),
    .sticky_flags(sticky2), .op_count(cnt2));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  fu;
    logic [4:0]  fs;
  } exp_t;

  exp_t        q[$];
  logic [31:0] got_q[$];
  int          checks = 0, failures = 0;
  int          cyc = 0, dlv_cnt = 0, last_dlv_cyc = 0;
  bit          mon_en = 1'b0;
  logic [4:0]  m_st1 = '0, m_st2 = '0;
  logic [15:0] m_c1 = '0;
  logic [3:0]  m_c2 = '0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t model(input logic [15:0] ma, mb, input logic [2:0] mop);
    exp_t e;
    logic [15:0] l;
    case (mop)
      3'd0: l = ma & mb;
      3'd1: l = ma | mb;
      3'd2: l = ma ^ mb;
      3'd3: l = ~(ma & mb);
      3'd4: l = ~(ma | mb);
      3'd5: l = ~(ma ^ mb);
      default: l = ~ma;
    endcase
    e.res = (mop == 3'd7) ? {ma, mb} : {16'h0, l};
    e.fu  = {ma == 16'h0, mb == 16'h0, ma == mb, ma > mb, ma < mb};
    e.fs  = {ma == 16'h0, mb == 16'h0, ma == mb, $signed(ma) > $signed(mb), $signed(ma) < $signed(mb)};
    return e;
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      exp_t e;
      logic dlv;
      checks++;
      if (sticky !== m_st1 || cnt !== m_c1) begin
        failures++;
        $display("FAIL acc_u: sticky=%b cnt=%0d expected sticky=%b cnt=%0d", sticky, cnt, m_st1, m_c1);
      end
      checks++;
      if (sticky2 !== m_st2 || cnt2 !== m_c2) begin
        failures++;
        $display("FAIL acc_s: sticky=%b cnt=%0d expected sticky=%b cnt=%0d", sticky2, cnt2, m_st2, m_c2);
      end
      if (rst) begin
        q.delete();
        m_st1 = '0; m_st2 = '0; m_c1 = '0; m_c2 = '0;
      end else begin
        e = '0;
        dlv = out_valid && out_ready;
        if (dlv) begin
          dlv_cnt++;
          last_dlv_cyc = cyc;
          got_q.push_back(outlu);
          checks++;
          if (q.size() == 0) begin
            failures++;
            $display("FAIL beat: unexpected beat outlu=%h", outlu);
          end else begin
            e = q.pop_front();
            if (outlu !== e.res || {za, zb, eq, gt, lt} !== e.fu ||
                outlu2 !== e.res || {za2, zb2, eq2, gt2, lt2} !== e.fs) begin
              failures++;
              $display("FAIL beat: outlu=%h f=%b outlu_s=%h f_s=%b expected outlu=%h f=%b f_s=%b",
                       outlu, {za, zb, eq, gt, lt}, outlu2, {za2, zb2, eq2, gt2, lt2}, e.res, e.fu, e.fs);
            end
          end
        end
        if (flag_clr) begin
          m_st1 = dlv ? e.fu : 5'd0;  m_c1 = dlv ? 16'd1 : 16'd0;
          m_st2 = dlv ? e.fs : 5'd0;  m_c2 = dlv ? 4'd1 : 4'd0;
        end else if (dlv) begin
          m_st1 = m_st1 | e.fu;  if (m_c1 != 16'hFFFF) m_c1 = m_c1 + 1'b1;
          m_st2 = m_st2 | e.fs;  if (m_c2 != 4'hF) m_c2 = m_c2 + 1'b1;
        end
        if (in_valid && in_ready) q.push_back(model(a, b, opcode));
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [15:0] ia, ib, input logic [2:0] iop);
    bit ok = 1'b0;
    a = ia; b = ib; opcode = iop; in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
      tick();
    end
    tick();
    in_valid = 1'b0;
    if (!ok) begin
      failures++;
      $display("FAIL send_timeout: in_ready=%b expected 1", in_ready);
    end
  endtask

  task automatic drain();
    bit ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (q.size() == 0 && !out_valid) begin ok = 1'b1; break; end
      tick();
    end
    tick();
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL drain_timeout: pending=%0d expected 0", q.size());
    end
  endtask

  task automatic wait_valid();
    bit ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (out_valid) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL valid_timeout: out_valid=%b expected 1", out_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; flag_clr = 1'b0;
    a = '0; b = '0; opcode = '0;
    repeat (3) tick();
    checks++;
    if (out_valid !== 1'b0 || outlu !== 32'h0 || {za, zb, eq, gt, lt} !== 5'b0) begin
      failures++;
      $display("FAIL reset_out: valid=%b outlu=%h flags=%b expected 0", out_valid, outlu, {za, zb, eq, gt, lt});
    end
    checks++;
    if (sticky !== 5'b0 || cnt !== 16'h0 || sticky2 !== 5'b0 || cnt2 !== 4'h0 || out_valid2 !== 1'b0) begin
      failures++;
      $display("FAIL reset_acc: sticky=%b cnt=%0d sticky_s=%b cnt_s=%0d expected 0", sticky, cnt, sticky2, cnt2);
    end
    mon_en = 1'b1;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_ops();
    logic [31:0] tbl [8] = '{32'h1, 32'hD, 32'hC, 32'hFFFE, 32'hFFF2, 32'hFFF3, 32'hFFF6, 32'h00090005};
    int cs;
    got_q.delete();
    out_ready = 1'b1;
    send(16'h0009, 16'h0005, 3'd0);
    cs = cyc;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL latency_early: out_valid=%b expected 0 one edge after accept", out_valid);
    end
    send(16'h0009, 16'h0005, 3'd1);
    checks++;
    if (out_valid !== 1'b1) begin
      failures++;
      $display("FAIL latency: out_valid=%b expected 1 two edges after accept", out_valid);
    end
    for (int op = 2; op < 8; op++) send(16'h0009, 16'h0005, 3'(op));
    drain();
    checks++;
    if (last_dlv_cyc - cs != 8) begin
      failures++;
      $display("FAIL throughput: last delivery %0d cycles after first accept expected 8", last_dlv_cyc - cs);
    end
    checks++;
    if (got_q.size() != 8) begin
      failures++;
      $display("FAIL ops_count: delivered=%0d expected 8", got_q.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (got_q[i] !== tbl[i]) begin
          failures++;
          $display("FAIL op_%0d: outlu=%h expected %h", i, got_q[i], tbl[i]);
        end
      end
    end
  endtask

  task automatic test_flags();
    for (int op = 0; op < 8; op++) send(16'h0003, 16'h000F, 3'(op));
    send(16'h00E9, 16'h00E9, 3'd0);
    send(16'h0000, 16'h0000, 3'd1);
    drain();
    checks++;
    if (sticky !== 5'b11111 || cnt !== 16'd18) begin
      failures++;
      $display("FAIL sticky_count: sticky=%b cnt=%0d expected 11111 18", sticky, cnt);
    end
    checks++;
    if (sticky2 !== 5'b11111 || cnt2 !== 4'hF) begin
      failures++;
      $display("FAIL sticky_count_s: sticky=%b cnt=%0d expected 11111 15", sticky2, cnt2);
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] ba [5] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555};
    logic [31:0] held = '0;
    bit have = 1'b0;
    bit acc_now;
    int idx = 0;
    int d0 = dlv_cnt;
    out_ready = 1'b0;
    a = ba[0]; b = 16'h00FF; opcode = 3'd2; in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (out_valid) begin
        if (!have) begin held = outlu; have = 1'b1; end
        else begin
          checks++;
          if (outlu !== held) begin
            failures++;
            $display("FAIL stall_hold: outlu=%h expected %h", outlu, held);
          end
        end
      end
      acc_now = in_ready;
      tick();
      if (acc_now) begin
        idx++;
        if (idx < 5) a = ba[idx];
      end
    end
    in_valid = 1'b0;
    checks++;
    if (idx != 2 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL stall_accept: accepted=%0d in_ready=%b expected 2 0", idx, in_ready);
    end
    out_ready = 1'b1;
    for (int i = idx; i < 5; i++) send(ba[i], 16'h00FF, 3'd2);
    drain();
    checks++;
    if (dlv_cnt - d0 != 5) begin
      failures++;
      $display("FAIL stall_release: delivered=%0d expected 5", dlv_cnt - d0);
    end
  endtask

  task automatic test_signed();
    out_ready = 1'b1;
    send(16'hFFFF, 16'h0001, 3'd0);
    wait_valid();
    checks++;
    if (gt !== 1'b1 || lt !== 1'b0 || lt2 !== 1'b1 || gt2 !== 1'b0) begin
      failures++;
      $display("FAIL signed_cmp: u gt/lt=%b%b s gt/lt=%b%b expected 10 01", gt, lt, gt2, lt2);
    end
    tick();
    drain();
  endtask

  task automatic test_sat_clr();
    flag_clr = 1'b1;
    tick();
    flag_clr = 1'b0;
    checks++;
    if (sticky !== 5'b0 || cnt !== 16'h0 || sticky2 !== 5'b0 || cnt2 !== 4'h0) begin
      failures++;
      $display("FAIL clr: sticky=%b cnt=%0d sticky_s=%b cnt_s=%0d expected 0", sticky, cnt, sticky2, cnt2);
    end
    for (int i = 0; i < 20; i++) send(16'(i * 37), 16'(i * 11 + 1), 3'(i));
    drain();
    checks++;
    if (cnt2 !== 4'hF || cnt !== 16'd20) begin
      failures++;
      $display("FAIL saturate: cnt_s=%h cnt=%0d expected F 20", cnt2, cnt);
    end
    out_ready = 1'b0;
    send(16'h0007, 16'h0007, 3'd2);
    tick();
    out_ready = 1'b1; flag_clr = 1'b1;
    tick();
    flag_clr = 1'b0;
    checks++;
    if (cnt !== 16'd1 || cnt2 !== 4'd1 || sticky !== 5'b00100 || sticky2 !== 5'b00100) begin
      failures++;
      $display("FAIL clr_dlv: cnt=%0d cnt_s=%0d sticky=%b sticky_s=%b expected 1 1 00100 00100",
               cnt, cnt2, sticky, sticky2);
    end
    drain();
  endtask

  task automatic test_reset_midflight();
    out_ready = 1'b0;
    send(16'h0001, 16'h0002, 3'd0);
    send(16'h0003, 16'h0004, 3'd1);
    rst = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0 || cnt !== 16'h0 || sticky !== 5'b0 || cnt2 !== 4'h0 || sticky2 !== 5'b0) begin
      failures++;
      $display("FAIL rst_mid: valid=%b cnt=%0d sticky=%b cnt_s=%0d sticky_s=%b expected 0",
               out_valid, cnt, sticky, cnt2, sticky2);
    end
    rst = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        failures++;
        $display("FAIL stale_beat: out_valid=%b outlu=%h expected 0", out_valid, outlu);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_ops();
    test_flags();
    test_backpressure();
    test_signed();
    test_sat_clr();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
